// File: rtl/issue_ctrl_pkg.sv
// Shared ISA types for the issue stage: instruction payload, station type,
// instruction name and the credit counter width.
package issue_ctrl_pkg;

  localparam int XLEN          = 32;
  localparam int ST_DEPTH_DEF  = 8;
  localparam int ROB_DEPTH_DEF = 32;

  // Station type doubles as the index into the per-station credit array.
  typedef enum logic [1:0] {
    ST_ALU = 2'd0,
    ST_LSU = 2'd1,
    ST_BR  = 2'd2,
    ST_MUL = 2'd3
  } st_type_e;

  // UNKNOWN marks a slot the resolver could not decode; it is a bubble.
  typedef enum logic [3:0] {
    UNKNOWN = 4'd0,
    ADD     = 4'd1,
    SUB     = 4'd2,
    LW      = 4'd3,
    SW      = 4'd4,
    BEQ     = 4'd5,
    BNE     = 4'd6,
    JAL     = 4'd7,
    MUL     = 4'd8,
    DIV     = 4'd9
  } instr_name_e;

  typedef struct packed {
    logic [XLEN-1:0] address;
    logic [XLEN-1:0] immediate;
    instr_name_e     instr_name;
    st_type_e        st_type;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [3:0]      flags;
  } instr_info_t;

  // Bits needed to hold any credit value from 0 up to the larger depth.
  function automatic int cred_width(input int st_depth, input int rob_depth);
    return $clog2(((st_depth > rob_depth) ? st_depth : rob_depth) + 1);
  endfunction

  localparam int CRED_W = cred_width(ST_DEPTH_DEF, ROB_DEPTH_DEF);

endpackage

// File: rtl/issue_credit_ctr.sv
// Free-entry credit counter for one reservation station or the ROB.
// Counts down on issue, up on release, saturates at DEPTH.
module issue_credit_ctr
  import issue_ctrl_pkg::*;
#(
  parameter int DEPTH = ST_DEPTH_DEF,
  parameter int CW    = CRED_W,
  parameter int RW    = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          flush,
  input  logic [RW-1:0] consume,
  input  logic [RW-1:0] rel,
  output logic [CW-1:0] credit
);

  localparam int SW = CW + 1;

  logic [SW-1:0] sum;
  logic          overflow;

  // Net credit after this cycle; one spare bit exposes an overflow.
  always_comb begin
    sum      = SW'(credit) + SW'(rel) - SW'(consume);
    overflow = (sum > SW'(DEPTH));
  end

  // Credit register: full on reset or flush, otherwise saturating update.
  // NOTE: state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      credit <= CW'(DEPTH);
    end else if (flush) begin
      credit <= CW'(DEPTH);
    end else if (overflow) begin
      credit <= CW'(DEPTH);
    end else begin
      credit <= sum[CW-1:0];
    end
  end

  // Releasing more entries than were ever taken is a protocol error upstream.
  a_no_overflow: assert property (@(posedge clk) disable iff (!reset || flush) !overflow);

endmodule

// File: rtl/issue_ctrl.sv
// N-way in-order issue stage. Issues the oldest contiguous prefix of a group
// that fits the station and ROB credits, parks the rest in a hold buffer and
// stalls upstream until the group has drained.
module issue_ctrl
  import issue_ctrl_pkg::*;
#(
  parameter int WIDTH     = 2,
  parameter int ST_COUNT  = 4,
  parameter int ST_DEPTH  = ST_DEPTH_DEF,
  parameter int ROB_DEPTH = ROB_DEPTH_DEF
) (
  input  logic                                      clk,
  input  logic                                      reset,
  input  logic                                      flush,
  input  logic        [WIDTH-1:0]                   in_valid,
  input  instr_info_t [WIDTH-1:0]                   in_instr,
  output logic                                      in_ready,
  output logic        [WIDTH-1:0]                   out_valid,
  output instr_info_t [WIDTH-1:0]                   out_instr,
  input  logic        [ST_COUNT-1:0][$clog2(WIDTH+1)-1:0] st_release,
  input  logic        [$clog2(WIDTH+1)-1:0]         rob_release,
  output logic                                      stop
);

  localparam int RW = $clog2(WIDTH + 1);
  localparam int CW = cred_width(ST_DEPTH, ROB_DEPTH);

  logic        [WIDTH-1:0]            hold_valid;
  instr_info_t [WIDTH-1:0]            hold_instr;
  logic        [WIDTH-1:0]            cand_valid;
  instr_info_t [WIDTH-1:0]            cand_instr;
  logic        [WIDTH-1:0]            issue;
  logic        [WIDTH-1:0]            remain;
  logic        [ST_COUNT-1:0][RW-1:0] st_consume;
  logic        [RW-1:0]               rob_consume;
  logic        [ST_COUNT-1:0][CW-1:0] st_credit;
  logic        [CW-1:0]               rob_credit;
  logic        [ST_COUNT-1:0][CW-1:0] run_st;
  logic        [CW-1:0]               run_rob;
  logic                               blocked;

  // The hold buffer occupancy is the only handshake state.
  assign in_ready = ~|hold_valid;
  assign stop     = ~in_ready;

  // Candidates: the parked remainder if any, else the incoming group.
  always_comb begin
    cand_valid = in_ready ? in_valid : hold_valid;
    cand_instr = in_ready ? in_instr : hold_instr;
  end

  // In-order select: walk slots from 0, spending running credits, and stop
  // at the first non-bubble slot that does not fit.
  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    issue       = '0;
    remain      = '0;
    st_consume  = '0;
    rob_consume = '0;
    run_st      = st_credit;
    run_rob     = rob_credit;
    blocked     = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (cand_valid[i] && (cand_instr[i].instr_name != UNKNOWN)) begin
        if (!blocked && (run_st[cand_instr[i].st_type] != '0) && (run_rob != '0)) begin
          issue[i]                           = 1'b1;
          run_st[cand_instr[i].st_type]      = run_st[cand_instr[i].st_type] - CW'(1);
          run_rob                            = run_rob - CW'(1);
          st_consume[cand_instr[i].st_type]  = st_consume[cand_instr[i].st_type] + RW'(1);
          rob_consume                        = rob_consume + RW'(1);
        end else begin
          blocked   = 1'b1;
          remain[i] = 1'b1;
        end
      end
    end
  end

  // Issue strobes and hold-buffer occupancy; flush drops everything in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_valid <= '0;
      out_valid  <= '0;
      out_instr  <= '0;
    end else if (flush) begin
      hold_valid <= '0;
      out_valid  <= '0;
    end else begin
      hold_valid <= remain;
      out_valid  <= issue;
      for (int i = 0; i < WIDTH; i++) begin
        out_instr[i] <= issue[i] ? cand_instr[i] : '0;
      end
    end
  end

  // Hold payload follows the candidates; a held slot reloads its own value.
  // NOTE: payload storage is not reset; hold_valid qualifies every read.
  always_ff @(posedge clk) begin
    hold_instr <= cand_instr;
  end

  for (genvar s = 0; s < ST_COUNT; s++) begin : g_st_ctr
    issue_credit_ctr #(
      .DEPTH (ST_DEPTH),
      .CW    (CW),
      .RW    (RW)
    ) u_st_ctr (
      .clk     (clk),
      .reset   (reset),
      .flush   (flush),
      .consume (st_consume[s]),
      .rel     (st_release[s]),
      .credit  (st_credit[s])
    );
  end

  issue_credit_ctr #(
    .DEPTH (ROB_DEPTH),
    .CW    (CW),
    .RW    (RW)
  ) u_rob_ctr (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .consume (rob_consume),
    .rel     (rob_release),
    .credit  (rob_credit)
  );

endmodule
